// File: rtl/ddr_responder.sv
// Main DDR port responder backed by an internal 2^ADDR_WIDTH x 64 memory.
// Optional busy injection is enabled by defining DDR_RESPONDER_BUSY_INJECT_EN.
module ddr_responder #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk_sys,
  input  logic        reset_sys_n,
  input  logic [7:0]  ddram_burstcnt,
  input  logic [28:0] ddram_addr,
  input  logic        ddram_rd,
  input  logic        ddram_we,
  input  logic [63:0] ddram_din,
  input  logic [7:0]  ddram_be,
  output logic        ddram_busy,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_ready,
  output logic        proto_err
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned WAIT_W    = 3;
  localparam int unsigned WAIT_INIT = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  logic [1:0]            rst_sync;
  logic                  rst_n_int;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      beats_q, beats_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  busy_q, busy_d;
  logic                  dout_ready_q, dout_ready_d;
  logic [63:0]           dout_q, dout_d;
  logic                  proto_err_q, proto_err_d;

  logic [63:0]           mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [ADDR_WIDTH-1:0] rd_idx;

  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic                  busy_inject;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^ddram_addr[28:ADDR_WIDTH];

  // Assert asynchronously, release two clk_sys edges after reset_sys_n rises.
  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign cmd_addr = ddram_addr[ADDR_WIDTH-1:0];
  assign cmd_len  = (ddram_burstcnt == 8'd0) ? 8'd1 : ddram_burstcnt;

`ifdef DDR_RESPONDER_BUSY_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11; busy_q mirrors lfsr_q LSBs == 00.
  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign busy_inject = (lfsr_d[1:0] == 2'b00);

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) lfsr_q <= 16'hACE1;
    else            lfsr_q <= lfsr_d;
  end
`else
  assign busy_inject = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_d      = beats_q;
    wait_d       = wait_q;
    dout_ready_d = 1'b0;
    dout_d       = dout_q;
    proto_err_d  = proto_err_q;
    mem_we       = 1'b0;
    mem_waddr    = addr_q;
    rd_idx       = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (rst_n_int && !busy_q) begin
          if (ddram_we) begin
            mem_we    = 1'b1;
            mem_waddr = cmd_addr;
            if (ddram_rd) proto_err_d = 1'b1;
            if (cmd_len > 8'd1) begin
              state_d = ST_WRITE;
              addr_d  = cmd_addr + ADDR_WIDTH'(1);
              beats_d = LEN_W'(cmd_len - 8'd1);
            end
          end else if (ddram_rd) begin
            state_d = ST_READ;
            addr_d  = cmd_addr;
            beats_d = cmd_len;
            wait_d  = WAIT_W'(WAIT_INIT);
            // Single-cycle latency: the first beat leaves on the accept edge.
            if (READ_LATENCY == 1) begin
              rd_idx       = cmd_addr;
              dout_ready_d = 1'b1;
              addr_d       = cmd_addr + ADDR_WIDTH'(1);
              beats_d      = LEN_W'(cmd_len - 8'd1);
            end
          end
        end
      end

      ST_READ: begin
        if (ddram_rd || ddram_we) proto_err_d = 1'b1;
        if (beats_q == 8'd0) begin
          state_d = ST_IDLE;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          rd_idx       = addr_q;
          dout_ready_d = 1'b1;
          addr_d       = addr_q + ADDR_WIDTH'(1);
          beats_d      = beats_q - 8'd1;
        end
      end

      ST_WRITE: begin
        if (ddram_rd) proto_err_d = 1'b1;
        if (ddram_we && !busy_q) begin
          mem_we  = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (dout_ready_d) dout_d = mem[rd_idx];
    busy_d = (state_d == ST_READ) || busy_inject;
  end

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      addr_q       <= '0;
      beats_q      <= '0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      dout_ready_q <= 1'b0;
      dout_q       <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      beats_q      <= beats_d;
      wait_q       <= wait_d;
      busy_q       <= busy_d;
      dout_ready_q <= dout_ready_d;
      dout_q       <= dout_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Backing store has no reset so contents survive a reset pulse.
  always_ff @(posedge clk_sys) begin
    for (int b = 0; b < 8; b++) begin
      if (mem_we && ddram_be[b]) mem[mem_waddr][8*b +: 8] <= ddram_din[8*b +: 8];
    end
  end

  assign ddram_busy       = busy_q;
  assign ddram_dout       = dout_q;
  assign ddram_dout_ready = dout_ready_q;
  assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_ddr_responder.sv
// Bench for ddr_responder: directed vectors, corner-case sequences and
// random bursts checked against a word-array memory model.
module tb_ddr_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic        clk_sys = 1'b0;
  logic        reset_sys_n;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic        ddram_rd;
  logic        ddram_we;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        proto_err;

  ddr_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk_sys          (clk_sys),
    .reset_sys_n      (reset_sys_n),
    .ddram_burstcnt   (ddram_burstcnt),
    .ddram_addr       (ddram_addr),
    .ddram_rd         (ddram_rd),
    .ddram_we         (ddram_we),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_busy       (ddram_busy),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .proto_err        (proto_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [9:0]  addr;
    logic [63:0] init;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wd [256];
  logic [7:0]  wbe [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          ok;
  int          seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Hold the presented command until an edge where busy is low.
  task automatic wait_accept();
    int t;
    t = 0;
    while (ddram_busy === 1'b1 && t < 500) begin
      @(posedge clk_sys); #1;
      t++;
    end
    if (t >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: busy=%b required 0", ddram_busy);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic do_write(input logic [28:0] a, input int n, input bit stalls);
    int nb;
    nb = (n == 0) ? 1 : n;
    for (int i = 0; i < nb; i++) begin
      if (stalls && i > 0) begin
        int s;
        s = $urandom_range(0, 2);
        ddram_we = 1'b0;
        for (int k = 0; k < s; k++) begin
          ddram_din = {$urandom, $urandom};
          @(posedge clk_sys); #1;
        end
      end
      ddram_we       = 1'b1;
      ddram_din      = wd[i];
      ddram_be       = wbe[i];
      ddram_addr     = (i == 0) ? a : 29'($urandom);
      ddram_burstcnt = (i == 0) ? 8'(n) : 8'($urandom);
      wait_accept();
      for (int b = 0; b < 8; b++)
        if (wbe[i][b]) ref_mem[10'(a + 29'(i))][8*b +: 8] = wd[i][8*b +: 8];
    end
    ddram_we = 1'b0;
  endtask

  // Ends in the cycle after the last beat, where busy should have dropped.
  task automatic do_read(input logic [28:0] a, input int n);
    int          nb;
    bit          tok;
    logic [63:0] last;
    nb             = (n == 0) ? 1 : n;
    ddram_addr     = a;
    ddram_burstcnt = 8'(n);
    ddram_rd       = 1'b1;
    wait_accept();
    ddram_rd       = 1'b0;
    ddram_addr     = 29'($urandom);
    ddram_burstcnt = 8'($urandom);
    tok  = 1'b1;
    last = '0;
    for (int cyc = 1; cyc <= int'(RL) + nb; cyc++) begin
      if (cyc >= int'(RL) && cyc < int'(RL) + nb) begin
        last = ref_mem[10'(a + 29'(cyc - int'(RL)))];
        if (ddram_dout_ready !== 1'b1) tok = 1'b0;
        if (ddram_busy !== 1'b1) tok = 1'b0;
        check("rd_data", ddram_dout, last);
      end else begin
        if (ddram_dout_ready !== 1'b0) tok = 1'b0;
        if (cyc < int'(RL) && ddram_busy !== 1'b1) tok = 1'b0;
        if (cyc == int'(RL) + nb && ddram_dout !== last) tok = 1'b0;
      end
      if (cyc < int'(RL) + nb) begin
        @(posedge clk_sys); #1;
      end
    end
    check("rd_timing", 64'(tok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10'h005, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 8'h0F, 64'hFFFFFFFF00000000};
    vecs[1] = '{10'h006, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 64'hFFFFFFFF00000000};
    vecs[2] = '{10'h007, 64'h1234567890ABCDEF, 64'h0000000000000000, 8'h00, 64'h1234567890ABCDEF};
    vecs[3] = '{10'h008, 64'h0000000000000000, 64'h0123456789ABCDEF, 8'h81, 64'h01000000000000EF};
    vecs[4] = '{10'h009, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 8'h3C, 64'hAAAA55555555AAAA};
    vecs[5] = '{10'h3FF, 64'h0000000000000000, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'hDEADBEEFCAFEF00D};

    reset_sys_n    = 1'b0;
    ddram_burstcnt = '0;
    ddram_addr     = '0;
    ddram_rd       = 1'b0;
    ddram_we       = 1'b0;
    ddram_din      = '0;
    ddram_be       = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_busy", 64'(ddram_busy), 64'd0);
    check("rst_ready", 64'(ddram_dout_ready), 64'd0);
    check("rst_dout", ddram_dout, 64'd0);
    check("rst_err", 64'(proto_err), 64'd0);
    reset_sys_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;

    // Give every word a known value.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 128; i++) begin
        wd[i]  = {$urandom, $urandom};
        wbe[i] = 8'hFF;
      end
      do_write(29'(blk * 128), 128, 1'b0);
    end

    // Four-beat write then read back at 0x10.
    wd[0] = 64'h1111111111111111; wd[1] = 64'h2222222222222222;
    wd[2] = 64'h3333333333333333; wd[3] = 64'h4444444444444444;
    for (int i = 0; i < 4; i++) wbe[i] = 8'hFF;
    do_write(29'h10, 4, 1'b0);
    do_read(29'h10, 4);
    check("burst4_last", ddram_dout, 64'h4444444444444444);
    check("burst4_err", 64'(proto_err), 64'd0);

    for (int v = 0; v < 6; v++) begin
      wd[0] = vecs[v].init;  wbe[0] = 8'hFF;
      do_write(29'(vecs[v].addr), 1, 1'b0);
      wd[0] = vecs[v].wdata; wbe[0] = vecs[v].be;
      do_write(29'(vecs[v].addr), 1, 1'b0);
      do_read(29'(vecs[v].addr), 1);
      check($sformatf("vec%0d", v), ddram_dout, vecs[v].exp);
    end

    // Burst crossing the top of memory wraps to address 0.
    wd[0] = 64'hA0A0A0A0A0A0A0A0; wd[1] = 64'hB0B0B0B0B0B0B0B0;
    wbe[0] = 8'hFF; wbe[1] = 8'hFF;
    do_write(29'h3FF, 2, 1'b0);
    do_read(29'h0, 1);
    check("wrap_b", ddram_dout, 64'hB0B0B0B0B0B0B0B0);
    do_read(29'h3FF, 1);
    check("wrap_a", ddram_dout, 64'hA0A0A0A0A0A0A0A0);

    // rd and we together: write wins, no beat, sticky error.
    ddram_addr = 29'd7; ddram_burstcnt = 8'd1; ddram_din = 64'hC0FFEE0012345678;
    ddram_be = 8'hFF; ddram_rd = 1'b1; ddram_we = 1'b1;
    wait_accept();
    ddram_rd = 1'b0; ddram_we = 1'b0;
    ref_mem[7] = 64'hC0FFEE0012345678;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (ddram_dout_ready !== 1'b0) ok = 1'b0;
      @(posedge clk_sys); #1;
    end
    check("rdwe_no_beat", 64'(ok), 64'd1);
    check("rdwe_err", 64'(proto_err), 64'd1);
    do_read(29'd7, 1);
    check("rdwe_data", ddram_dout, 64'hC0FFEE0012345678);
    check("rdwe_err_sticky", 64'(proto_err), 64'd1);

    // Reset in the middle of an eight-beat read.
    ddram_addr = 29'h40; ddram_burstcnt = 8'd8; ddram_rd = 1'b1;
    wait_accept();
    ddram_rd = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      if (ddram_dout_ready === 1'b1) seen++;
      if (seen < 3) begin
        @(posedge clk_sys); #1;
      end
    end
    check("mid_beats_seen", 64'(seen), 64'd3);
    #1 reset_sys_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ddram_dout_ready), 64'd0);
    check("mid_rst_busy", 64'(ddram_busy), 64'd0);
    check("mid_rst_dout", ddram_dout, 64'd0);
    check("mid_rst_err", 64'(proto_err), 64'd0);
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_sys); #1;
      if (ddram_dout_ready !== 1'b0) ok = 1'b0;
    end
    reset_sys_n = 1'b1;
    // A write held over the first two edges after release must be dropped.
    ddram_addr = 29'h20; ddram_burstcnt = 8'd1; ddram_din = 64'hBADBADBADBADBAD0;
    ddram_be = 8'hFF; ddram_we = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_sys); #1;
      if (ddram_dout_ready !== 1'b0) ok = 1'b0;
    end
    ddram_we = 1'b0;
    check("mid_no_beats", 64'(ok), 64'd1);
    repeat (2) @(posedge clk_sys);
    #1;
    do_read(29'h40, 8);
    do_read(29'h20, 1);

    // Random bursts against the model.
    for (int op = 0; op < 300; op++) begin
      logic [28:0] ra;
      int          n;
      ra = 29'($urandom);
      n  = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 40) : $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 256; i++) begin
          wd[i]  = {$urandom, $urandom};
          wbe[i] = 8'($urandom);
        end
        do_write(ra, n, 1'b1);
      end else begin
        do_read(ra, n);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_sys); #1;
      end
    end
    check("final_err", 64'(proto_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
